column_store: RTL and testbench

- Double-buffered (ping-pong) per-column store between the ray pipeline (height_calculator / ray_calculator outputs) and the pixel renderer.
- Each result is one word per screen column: wall height, lighting factor and texture x.
- The ray side writes the back bank; the renderer reads the front bank.
- Banks swap only at a frame boundary, so a frame is never torn. The block also owns write_new_frame and data_initialised.

---
 rtl/raycast_pkg.sv | 16 +
 rtl/column_store_if.sv | 28 ++
 rtl/column_bank.sv | 25 ++
 rtl/column_store.sv | 99 +++++++++
 tb/tb_column_store.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/raycast_pkg.sv
// raycast_pkg: shared widths, column word and column_store state encoding
package raycast_pkg;
    localparam int SCREEN_WIDTH = 640;
    localparam int IDX_W        = 10;
    localparam int HEIGHT_W     = 9;
    localparam int LIGHT_W      = 2;
    localparam int TEX_W        = 4;

    typedef struct packed {
        logic [HEIGHT_W-1:0] height;
        logic [LIGHT_W-1:0]  light;
        logic [TEX_W-1:0]    tex;
    } column_t;

    typedef enum logic [1:0] {INIT, FILL, WAIT_SWAP} cs_state_e;
endpackage

// File: rtl/column_store_if.sv
// column_store_if: ray-side write bus, renderer read bus and frame status
interface column_store_if;
    import raycast_pkg::*;
    logic                wr_valid;
    logic [IDX_W-1:0]    wr_index;
    logic [HEIGHT_W-1:0] wr_height;
    logic [LIGHT_W-1:0]  wr_light;
    logic [TEX_W-1:0]    wr_tex;
    logic                frame_start;
    logic                rd_en;
    logic [IDX_W-1:0]    rd_index;
    logic                rd_valid;
    logic [HEIGHT_W-1:0] rd_height;
    logic [LIGHT_W-1:0]  rd_light;
    logic [TEX_W-1:0]    rd_tex;
    logic                write_new_frame;
    logic                data_initialised;
    logic [7:0]          frames_missed;

    modport master (
        output wr_valid, wr_index, wr_height, wr_light, wr_tex, frame_start, rd_en, rd_index,
        input  rd_valid, rd_height, rd_light, rd_tex, write_new_frame, data_initialised, frames_missed
    );
    modport slave (
        input  wr_valid, wr_index, wr_height, wr_light, wr_tex, frame_start, rd_en, rd_index,
        output rd_valid, rd_height, rd_light, rd_tex, write_new_frame, data_initialised, frames_missed
    );
endinterface

// File: rtl/column_bank.sv
// column_bank: one-write, one-read column RAM with registered read data
module column_bank
    import raycast_pkg::*;
#(
    parameter int DEPTH = SCREEN_WIDTH
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  column_t          wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output column_t          rdata_o
);
    column_t mem_q [DEPTH];
    column_t rdata_q;

    // write port and registered read port; read data holds while re_i is low
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/column_store.sv
// column_store: ping-pong per-column store; frames_missed counter built only with COLUMN_STORE_MISS_CNT_EN
module column_store
    import raycast_pkg::*;
#(
    parameter int WIDTH = SCREEN_WIDTH
) (
    input logic clk,
    input logic reset,
    column_store_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    cs_state_e state_q;
    logic      front_q, wnf_q, init_q;
    logic      rd_valid_q, sel_q, zero_q;
    column_t   wdata, rdata0, rdata1, rd_word;
    logic      wr_ok, complete, rd_ok;

    assign wr_ok    = bus.wr_valid && wnf_q && bus.wr_index <= LAST;
    assign complete = wr_ok && bus.wr_index == LAST;
    assign rd_ok    = bus.rd_en && bus.rd_index <= LAST;
    assign wdata    = '{height: bus.wr_height, light: bus.wr_light, tex: bus.wr_tex};

    column_bank #(.DEPTH(WIDTH)) u_bank0 (
        .clk(clk), .we_i(wr_ok && front_q), .waddr_i(bus.wr_index), .wdata_i(wdata),
        .re_i(rd_ok), .raddr_i(bus.rd_index), .rdata_o(rdata0)
    );
    column_bank #(.DEPTH(WIDTH)) u_bank1 (
        .clk(clk), .we_i(wr_ok && !front_q), .waddr_i(bus.wr_index), .wdata_i(wdata),
        .re_i(rd_ok), .raddr_i(bus.rd_index), .rdata_o(rdata1)
    );

    // frame FSM: swaps the banks only at a frame boundary (or on the very first frame)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            front_q <= 1'b0;
            wnf_q   <= 1'b1;
            init_q  <= 1'b0;
        end else begin
            case (state_q)
                INIT: if (complete) begin
                    front_q <= ~front_q;
                    init_q  <= 1'b1;
                    state_q <= FILL;
                end
                FILL: if (complete && bus.frame_start) begin
                    front_q <= ~front_q;
                end else if (complete) begin
                    state_q <= WAIT_SWAP;
                    wnf_q   <= 1'b0;
                end
                WAIT_SWAP: if (bus.frame_start) begin
                    front_q <= ~front_q;
                    wnf_q   <= 1'b1;
                    state_q <= FILL;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    // read side: remember which bank was front and whether the result is forced to zero at issue
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            sel_q      <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                sel_q  <= front_q;
                zero_q <= !rd_ok || !init_q;
            end
        end
    end

    assign rd_word              = zero_q ? '0 : (sel_q ? rdata1 : rdata0);
    assign bus.rd_valid         = rd_valid_q;
    assign bus.rd_height        = rd_word.height;
    assign bus.rd_light         = rd_word.light;
    assign bus.rd_tex           = rd_word.tex;
    assign bus.write_new_frame  = wnf_q;
    assign bus.data_initialised = init_q;

`ifdef COLUMN_STORE_MISS_CNT_EN
    logic [7:0] miss_q;

    // saturating count of frame_start pulses that found the back frame unfinished
    always_ff @(posedge clk) begin
        if (reset) miss_q <= '0;
        else if (state_q == FILL && bus.frame_start && !complete && miss_q != 8'hff) miss_q <= miss_q + 8'd1;
    end

    assign bus.frames_missed = miss_q;
`else
    assign bus.frames_missed = '0;
`endif
endmodule

// File: tb/tb_column_store.sv
// tb_column_store: randomized self-checking bench for column_store against a frame-level model
module tb_column_store;
    import raycast_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    column_store_if bus();
    column_store dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic [14:0] bank_m [2][640];
    int          front_m, mode_m, miss_m;
    logic        wnf_m, init_m, exp_valid;
    logic [14:0] exp_word;

    function automatic logic [14:0] w(input int h, input int l, input int t);
        logic [8:0] hh = h[8:0];
        logic [1:0] ll = l[1:0];
        logic [3:0] tt = t[3:0];
        return {hh, ll, tt};
    endfunction

    function automatic logic [7:0] fm_exp();
`ifdef COLUMN_STORE_MISS_CNT_EN
        return 8'(miss_m);
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [14:0] got();
        return {bus.rd_height, bus.rd_light, bus.rd_tex};
    endfunction

    task automatic step(input logic wv, input int widx, input logic [14:0] wd,
                        input logic fs, input logic re, input int ridx);
        logic acc, cmp;
        bus.wr_valid = wv;
        bus.wr_index = widx[9:0];
        {bus.wr_height, bus.wr_light, bus.wr_tex} = wd;
        bus.frame_start = fs;
        bus.rd_en = re;
        bus.rd_index = ridx[9:0];
        acc = wv && wnf_m && widx < 640;
        cmp = acc && widx == 639;
        exp_valid = re;
        if (re) exp_word = (ridx < 640 && init_m) ? bank_m[front_m][ridx] : 15'd0;
        if (acc) bank_m[1-front_m][widx] = wd;
        if (mode_m == 0) begin
            if (cmp) begin front_m = 1 - front_m; init_m = 1'b1; mode_m = 1; end
        end else if (mode_m == 1) begin
            if (cmp && fs) front_m = 1 - front_m;
            else if (cmp) begin mode_m = 2; wnf_m = 1'b0; end
            else if (fs && miss_m < 255) miss_m++;
        end else if (fs) begin
            front_m = 1 - front_m; wnf_m = 1'b1; mode_m = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 15'd0, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_index = '0; bus.wr_height = '0; bus.wr_light = '0; bus.wr_tex = '0;
        bus.frame_start = 1'b0; bus.rd_en = 1'b0; bus.rd_index = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        front_m = 0; mode_m = 0; miss_m = 0; wnf_m = 1'b1; init_m = 1'b0;
        exp_valid = 1'b0; exp_word = 15'd0;
    endtask

    task automatic rand_reads(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 0, 15'd0, 1'b0, 1'b1, $urandom_range(0, 639));
            checks++;
            if (bus.rd_valid !== 1'b1 || got() !== exp_word) begin
                failures++;
                $display("FAIL %s read: got valid=%b word=%h want valid=1 word=%h", name, bus.rd_valid, got(), exp_word);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset rd_valid: got %b want 0", bus.rd_valid); end
        if (got() !== 15'd0) begin failures++; $display("FAIL reset rd_word: got %h want 0", got()); end
        if (bus.write_new_frame !== 1'b1 || bus.data_initialised !== 1'b0) begin
            failures++; $display("FAIL reset flags: got wnf=%b di=%b want 1 0", bus.write_new_frame, bus.data_initialised);
        end
        if (bus.frames_missed !== 8'd0) begin failures++; $display("FAIL reset frames_missed: got %0d want 0", bus.frames_missed); end
    endtask

    task automatic test_fill();
        step(1'b0, 0, 15'd0, 1'b0, 1'b1, 5);
        checks++;
        if (bus.rd_valid !== 1'b1 || got() !== 15'd0) begin
            failures++; $display("FAIL uninit read: got valid=%b word=%h want 1 0", bus.rd_valid, got());
        end
        for (int i = 0; i < 640; i++) step(1'b1, i, w(i, 1, i), ($urandom_range(0, 15) == 0), 1'b0, 0);
        checks++;
        if (bus.data_initialised !== 1'b1 || bus.write_new_frame !== 1'b1) begin
            failures++; $display("FAIL first frame flags: got di=%b wnf=%b want 1 1", bus.data_initialised, bus.write_new_frame);
        end
        step(1'b0, 0, 15'd0, 1'b0, 1'b1, 100);
        checks++;
        if (bus.rd_valid !== 1'b1 || got() !== w(100, 1, 4)) begin
            failures++; $display("FAIL col100 read: got valid=%b word=%h want 1 %h", bus.rd_valid, got(), w(100, 1, 4));
        end
        idle();
        checks++;
        if (bus.rd_valid !== 1'b0 || got() !== w(100, 1, 4)) begin
            failures++; $display("FAIL read hold: got valid=%b word=%h want 0 %h", bus.rd_valid, got(), w(100, 1, 4));
        end
        rand_reads("frame1", 20);
    endtask

    task automatic test_wait_swap();
        for (int i = 638; i >= 0; i--) step(1'b1, i, w(50, $urandom, $urandom), 1'b0, 1'b0, 0);
        step(1'b1, 639, w(50, 2, 3), 1'b0, 1'b0, 0);
        checks++;
        if (bus.write_new_frame !== 1'b0) begin failures++; $display("FAIL wait wnf: got %b want 0", bus.write_new_frame); end
        step(1'b1, 5, w(77, 0, 0), 1'b0, 1'b1, 5);
        checks++;
        if (got() !== w(5, 1, 5)) begin failures++; $display("FAIL wait old data: got %h want %h", got(), w(5, 1, 5)); end
        rand_reads("wait", 10);
        step(1'b0, 0, 15'd0, 1'b1, 1'b1, 10);
        checks++;
        if (got() !== w(10, 1, 10) || bus.write_new_frame !== 1'b1) begin
            failures++; $display("FAIL swap issue cycle: got word=%h wnf=%b want %h 1", got(), bus.write_new_frame, w(10, 1, 10));
        end
        step(1'b0, 0, 15'd0, 1'b0, 1'b1, 5);
        checks++;
        if (got() !== exp_word || bus.rd_height !== 9'd50) begin
            failures++; $display("FAIL after swap: got word=%h height=%0d want %h 50", got(), bus.rd_height, exp_word);
        end
        rand_reads("frame2", 10);
    endtask

    task automatic test_miss();
        logic [14:0] old;
        for (int i = 0; i <= 300; i++) step(1'b1, i, w($urandom, $urandom, $urandom), 1'b0, 1'b0, 0);
        step(1'b0, 0, 15'd0, 1'b1, 1'b0, 0);
        step(1'b0, 0, 15'd0, 1'b0, 1'b1, 200);
        old = exp_word;
        checks += 2;
        if (got() !== old || bus.rd_height !== 9'd50) begin
            failures++; $display("FAIL miss no swap: got %h height=%0d want %h 50", got(), bus.rd_height, old);
        end
`ifdef COLUMN_STORE_MISS_CNT_EN
        if (bus.frames_missed !== 8'd1) begin failures++; $display("FAIL miss count: got %0d want 1", bus.frames_missed); end
`else
        if (bus.frames_missed !== 8'd0) begin failures++; $display("FAIL miss count: got %0d want 0", bus.frames_missed); end
`endif
    endtask

    task automatic test_coincide();
        for (int i = 301; i < 639; i++) step(1'b1, i, w($urandom, $urandom, $urandom), 1'b0, 1'b0, 0);
        step(1'b1, 639, w(321, 3, 9), 1'b1, 1'b1, 639);
        checks++;
        if (got() !== w(50, 2, 3) || bus.write_new_frame !== 1'b1) begin
            failures++; $display("FAIL coincide issue: got %h wnf=%b want %h 1", got(), bus.write_new_frame, w(50, 2, 3));
        end
        step(1'b0, 0, 15'd0, 1'b0, 1'b1, 639);
        checks++;
        if (got() !== w(321, 3, 9)) begin failures++; $display("FAIL coincide new data: got %h want %h", got(), w(321, 3, 9)); end
        rand_reads("frame3", 10);
        step(1'b1, 639, w(1, 1, 1), 1'b0, 1'b0, 0);
        checks++;
        if (bus.write_new_frame !== 1'b0) begin failures++; $display("FAIL still fill: got wnf=%b want 0", bus.write_new_frame); end
        step(1'b0, 0, 15'd0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_out_of_range();
        step(1'b1, 700, w(99, 3, 15), 1'b0, 1'b1, 700);
        checks++;
        if (bus.rd_valid !== 1'b1 || got() !== 15'd0) begin
            failures++; $display("FAIL range read: got valid=%b word=%h want 1 0", bus.rd_valid, got());
        end
        step(1'b0, 0, 15'd0, 1'b0, 1'b1, 60);
        checks++;
        if (got() !== exp_word) begin failures++; $display("FAIL range alias: got %h want %h", got(), exp_word); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 100; i++) step(1'b1, i, w(200, 0, 1), 1'b0, 1'b0, 0);
        do_reset();
        checks++;
        if (bus.data_initialised !== 1'b0 || bus.write_new_frame !== 1'b1 || bus.rd_valid !== 1'b0) begin
            failures++; $display("FAIL mid reset flags: got di=%b wnf=%b v=%b want 0 1 0", bus.data_initialised, bus.write_new_frame, bus.rd_valid);
        end
        for (int i = 0; i < 640; i++) begin
            step(1'b1, i, w(i + 7, 2, i), ($urandom_range(0, 7) == 0), (i % 64 == 0), i);
            if (i % 64 == 0) begin
                checks++;
                if (got() !== 15'd0) begin failures++; $display("FAIL mid reset zero: got %h want 0", got()); end
            end
        end
        rand_reads("after reset", 15);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) step(1'b0, 0, 15'd0, 1'b1, 1'b0, 0);
        checks++;
        if (bus.frames_missed !== fm_exp()) begin failures++; $display("FAIL saturate: got %0d want %0d", bus.frames_missed, fm_exp()); end
    endtask

    task automatic test_random();
        int wi;
        for (int c = 0; c < 600; c++) begin
            wi = ($urandom_range(0, 7) == 0) ? 639 : $urandom_range(0, 700);
            step($urandom_range(0, 1), wi, w($urandom, $urandom, $urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 660));
            checks++;
            if (bus.rd_valid !== exp_valid || got() !== exp_word || bus.write_new_frame !== wnf_m ||
                bus.data_initialised !== init_m || bus.frames_missed !== fm_exp()) begin
                failures++;
                $display("FAIL random cycle %0d: got v=%b word=%h wnf=%b di=%b fm=%0d want v=%b word=%h wnf=%b di=%b fm=%0d",
                         c, bus.rd_valid, got(), bus.write_new_frame, bus.data_initialised, bus.frames_missed,
                         exp_valid, exp_word, wnf_m, init_m, fm_exp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wait_swap();
        test_miss();
        test_coincide();
        test_out_of_range();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
